// File: rtl/ahblite_interconnect_resp_mux.sv
// AHB-Lite data-phase response mux with built-in default slave (two-cycle ERROR for unmapped transfers).
// Optional multi-select checking is enabled by defining AHBLITE_RESP_MUX_ONEHOT_CHK_EN.
module ahblite_interconnect_resp_mux #(
  parameter int NUM_SLV = 4,
  parameter int DW      = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [NUM_SLV-1:0]    HSEL_i,
  input  logic [1:0]            HTRANS,
  input  logic [NUM_SLV*DW-1:0] HRDATA_s,
  input  logic [NUM_SLV-1:0]    HREADYOUT_s,
  input  logic [NUM_SLV-1:0]    HRESP_s,
  output logic [DW-1:0]         HRDATA,
  output logic                  HREADY,
  output logic                  HRESP,
  output logic                  err_multi_o
);

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  logic [NUM_SLV:0] sel_q, sel_d, sel_new;
  ds_state_e        ds_q, ds_d;
  logic             found;
  logic             err_start;

`ifdef AHBLITE_RESP_MUX_ONEHOT_CHK_EN
  logic             multi_hot;
  logic             err_multi_q, err_multi_d;
  int               hot_cnt;
`endif

  // Address phase: priority-encode the decoder select; slot NUM_SLV is the default slave
  always_comb begin
    sel_new = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (HSEL_i[k] && !found) begin
        sel_new[k] = 1'b1;
        found      = 1'b1;
      end
    end
`ifdef AHBLITE_RESP_MUX_ONEHOT_CHK_EN
    hot_cnt = 0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (HSEL_i[k]) hot_cnt = hot_cnt + 1;
    end
    multi_hot = (hot_cnt > 1);
    if (multi_hot) begin
      sel_new = '0;
      found   = 1'b0;
    end
`endif
    if (!found) sel_new[NUM_SLV] = 1'b1;
  end

  assign sel_d     = HREADY ? sel_new : sel_q;
  assign err_start = HREADY && sel_new[NUM_SLV] && HTRANS[1];

  always_comb begin
    ds_d = ds_q;
    unique case (ds_q)
      DS_IDLE: if (err_start) ds_d = DS_ERR1;
      DS_ERR1: ds_d = DS_ERR2;
      DS_ERR2: ds_d = err_start ? DS_ERR1 : DS_IDLE;
      default: ds_d = DS_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_q <= (NUM_SLV+1)'(1) << NUM_SLV;
      ds_q  <= DS_IDLE;
    end else begin
      sel_q <= sel_d;
      ds_q  <= ds_d;
    end
  end

`ifdef AHBLITE_RESP_MUX_ONEHOT_CHK_EN
  // Sticky: only reset clears it
  assign err_multi_d = err_multi_q | (HREADY & multi_hot);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) err_multi_q <= 1'b0;
    else          err_multi_q <= err_multi_d;
  end

  assign err_multi_o = err_multi_q;
`else
  assign err_multi_o = 1'b0;
`endif

  // Data phase: purely combinational from the registered select
  always_comb begin
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (sel_q[k]) begin
        HRDATA = HRDATA_s[k*DW +: DW];
        HREADY = HREADYOUT_s[k];
        HRESP  = HRESP_s[k];
      end
    end
    if (sel_q[NUM_SLV]) begin
      HRDATA = '0;
      HREADY = (ds_q != DS_ERR1);
      HRESP  = (ds_q != DS_IDLE);
    end
  end

endmodule

// File: tb/tb_ahblite_interconnect_resp_mux.sv
// Table-driven scoreboard bench for ahblite_interconnect_resp_mux (NUM_SLV=4, DW=32).
module tb_ahblite_interconnect_resp_mux;

  localparam logic [1:0] T_IDLE = 2'b00, T_NSEQ = 2'b10, T_SEQ = 2'b11;
`ifdef AHBLITE_RESP_MUX_ONEHOT_CHK_EN
  localparam logic MULTI = 1'b1;
`else
  localparam logic MULTI = 1'b0;
`endif

  logic         HCLK = 1'b0;
  logic         HRESETn;
  logic [3:0]   HSEL_i;
  logic [1:0]   HTRANS;
  logic [127:0] HRDATA_s;
  logic [3:0]   HREADYOUT_s;
  logic [3:0]   HRESP_s;
  logic [31:0]  HRDATA;
  logic         HREADY;
  logic         HRESP;
  logic         err_multi_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  hsel;
    logic [1:0]  htrans;
    logic [3:0]  rdy;
    logic [3:0]  resp;
    logic        e_rdy;
    logic        e_resp;
    logic [31:0] e_data;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic        e_rdy;
    logic        e_resp;
    logic [31:0] e_data;
    logic        e_err;
    int          idx;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[31];

  ahblite_interconnect_resp_mux #(.NUM_SLV(4), .DW(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL_i(HSEL_i), .HTRANS(HTRANS),
    .HRDATA_s(HRDATA_s), .HREADYOUT_s(HREADYOUT_s), .HRESP_s(HRESP_s),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .err_multi_o(err_multi_o)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(input logic [3:0] hsel, input logic [1:0] htrans,
                              input logic [3:0] rdy, input logic [3:0] resp,
                              input logic er, input logic es, input logic [31:0] ed,
                              input logic ee);
    vec_t v;
    v.hsel = hsel; v.htrans = htrans; v.rdy = rdy; v.resp = resp;
    v.e_rdy = er; v.e_resp = es; v.e_data = ed; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    @(posedge HCLK); #1;
    HSEL_i = v.hsel; HTRANS = v.htrans; HREADYOUT_s = v.rdy; HRESP_s = v.resp;
    e.e_rdy = v.e_rdy; e.e_resp = v.e_resp; e.e_data = v.e_data; e.e_err = v.e_err; e.idx = idx;
    sb.push_back(e);
    @(negedge HCLK);
    e = sb.pop_front();
    chk("hready", e.idx, 32'(HREADY), 32'(e.e_rdy));
    chk("hresp", e.idx, 32'(HRESP), 32'(e.e_resp));
    chk("hrdata", e.idx, HRDATA, e.e_data);
    chk("err_multi", e.idx, 32'(err_multi_o), 32'(e.e_err));
  endtask

  initial begin
    // idle baseline
    tbl[0]  = mk(4'b0000, T_IDLE, 4'hF, 4'h0, 1, 0, 32'h0, 0);
    // slave 1 read with two wait states
    tbl[1]  = mk(4'b0010, T_NSEQ, 4'hF, 4'h0, 1, 0, 32'h0, 0);
    tbl[2]  = mk(4'b0000, T_IDLE, 4'hD, 4'h0, 0, 0, 32'hA5A50001, 0);
    tbl[3]  = mk(4'b0000, T_IDLE, 4'hD, 4'h0, 0, 0, 32'hA5A50001, 0);
    tbl[4]  = mk(4'b0000, T_IDLE, 4'hF, 4'h0, 1, 0, 32'hA5A50001, 0);
    tbl[5]  = mk(4'b0000, T_IDLE, 4'hF, 4'h0, 1, 0, 32'h0, 0);
    // unmapped NONSEQ -> two-cycle ERROR
    tbl[6]  = mk(4'b0000, T_NSEQ, 4'hF, 4'h0, 1, 0, 32'h0, 0);
    tbl[7]  = mk(4'b0000, T_IDLE, 4'hF, 4'h0, 0, 1, 32'h0, 0);
    tbl[8]  = mk(4'b0000, T_IDLE, 4'hF, 4'h0, 1, 1, 32'h0, 0);
    tbl[9]  = mk(4'b0000, T_IDLE, 4'hF, 4'h0, 1, 0, 32'h0, 0);
    // back-to-back slave 0 then slave 3
    tbl[10] = mk(4'b0001, T_NSEQ, 4'hF, 4'h0, 1, 0, 32'h0, 0);
    tbl[11] = mk(4'b1000, T_NSEQ, 4'hF, 4'h0, 1, 0, 32'h11111111, 0);
    tbl[12] = mk(4'b0000, T_IDLE, 4'hF, 4'h0, 1, 0, 32'h33333333, 0);
    tbl[13] = mk(4'b0000, T_IDLE, 4'hF, 4'h0, 1, 0, 32'h0, 0);
    // two consecutive unmapped SEQ; the one held during ERR1 is not captured
    tbl[14] = mk(4'b0000, T_SEQ,  4'hF, 4'h0, 1, 0, 32'h0, 0);
    tbl[15] = mk(4'b0000, T_SEQ,  4'hF, 4'h0, 0, 1, 32'h0, 0);
    tbl[16] = mk(4'b0000, T_SEQ,  4'hF, 4'h0, 1, 1, 32'h0, 0);
    tbl[17] = mk(4'b0000, T_IDLE, 4'hF, 4'h0, 0, 1, 32'h0, 0);
    tbl[18] = mk(4'b0000, T_IDLE, 4'hF, 4'h0, 1, 1, 32'h0, 0);
    tbl[19] = mk(4'b0000, T_IDLE, 4'hF, 4'h0, 1, 0, 32'h0, 0);
    // slave 2 ERROR passed through unmodified
    tbl[20] = mk(4'b0100, T_NSEQ, 4'hF, 4'h0, 1, 0, 32'h0, 0);
    tbl[21] = mk(4'b0000, T_IDLE, 4'hB, 4'h4, 0, 1, 32'h22222222, 0);
    tbl[22] = mk(4'b0000, T_IDLE, 4'hF, 4'h4, 1, 1, 32'h22222222, 0);
    tbl[23] = mk(4'b0000, T_IDLE, 4'hF, 4'h0, 1, 0, 32'h0, 0);
    // mapped IDLE routes to the slave
    tbl[24] = mk(4'b0001, T_IDLE, 4'hF, 4'h0, 1, 0, 32'h0, 0);
    tbl[25] = mk(4'b0000, T_IDLE, 4'hF, 4'h0, 1, 0, 32'h11111111, 0);
    tbl[26] = mk(4'b0000, T_IDLE, 4'hF, 4'h0, 1, 0, 32'h0, 0);
    // multi-hot select
    tbl[27] = mk(4'b0110, T_NSEQ, 4'hF, 4'h0, 1, 0, 32'h0, 0);
    if (MULTI) begin
      tbl[28] = mk(4'b0000, T_IDLE, 4'hF, 4'h0, 0, 1, 32'h0, 1);
      tbl[29] = mk(4'b0000, T_IDLE, 4'hF, 4'h0, 1, 1, 32'h0, 1);
      tbl[30] = mk(4'b0000, T_IDLE, 4'hF, 4'h0, 1, 0, 32'h0, 1);
    end else begin
      tbl[28] = mk(4'b0000, T_IDLE, 4'hF, 4'h0, 1, 0, 32'hA5A50001, 0);
      tbl[29] = mk(4'b0000, T_IDLE, 4'hF, 4'h0, 1, 0, 32'h0, 0);
      tbl[30] = mk(4'b0000, T_IDLE, 4'hF, 4'h0, 1, 0, 32'h0, 0);
    end

    HRESETn = 1'b0;
    HSEL_i = '0; HTRANS = T_IDLE; HREADYOUT_s = 4'hF; HRESP_s = '0;
    HRDATA_s = {32'h33333333, 32'h22222222, 32'hA5A50001, 32'h11111111};
    repeat (2) @(negedge HCLK);
    chk("rst_hready", -1, 32'(HREADY), 32'd1);
    chk("rst_hresp", -1, 32'(HRESP), 32'd0);
    chk("rst_hrdata", -1, HRDATA, 32'h0);
    chk("rst_err_multi", -1, 32'(err_multi_o), 32'd0);
    HRESETn = 1'b1;

    for (int i = 0; i < 31; i++) run_vec(tbl[i], i);

    // async reset while the default slave sits in ERR1
    run_vec(mk(4'b0000, T_NSEQ, 4'hF, 4'h0, 1, 0, 32'h0, MULTI), 100);
    @(posedge HCLK); #1;
    HSEL_i = '0; HTRANS = T_IDLE;
    #1;
    chk("err1_hready", 101, 32'(HREADY), 32'd0);
    chk("err1_hresp", 101, 32'(HRESP), 32'd1);
    HRESETn = 1'b0;
    #1;
    chk("arst_hready", 102, 32'(HREADY), 32'd1);
    chk("arst_hresp", 102, 32'(HRESP), 32'd0);
    chk("arst_hrdata", 102, HRDATA, 32'h0);
    chk("arst_err_multi", 102, 32'(err_multi_o), 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    run_vec(mk(4'b1000, T_NSEQ, 4'hF, 4'h0, 1, 0, 32'h0, 0), 103);
    run_vec(mk(4'b0000, T_IDLE, 4'hF, 4'h0, 1, 0, 32'h33333333, 0), 104);

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    checks++;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahblite_interconnect_resp_mux.md
# ahblite_interconnect_resp_mux

Data-phase response multiplexer for the AHB-Lite interconnect: the return path that pairs with the address decoder/comparator chain. It registers the decoder's slave-select in the address phase. In the following data phase it routes the selected slave's HRDATA/HREADYOUT/HRESP back to the master. It contains a built-in default slave that returns the two-cycle AHB ERROR response for unmapped NONSEQ/SEQ transfers. It sits between the slave ports and the single master port.

## Interface
- NUM_SLV, 4: number of slave ports (1..16).
- DW, 32: data width.
- HCLK  in  1  bus clock; all state updates on its rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL_i  in  NUM_SLV  address-phase select from decoder; all-zero means unmapped.
- HTRANS  in  2  master transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- HRDATA_s  in  NUM_SLV*DW  slave read data, slave k at bits [k*DW +: DW].
- HREADYOUT_s  in  NUM_SLV  slave ready outputs.
- HRESP_s  in  NUM_SLV  slave responses (0 OKAY, 1 ERROR).
- HRDATA  out  DW  read data to master.
- HREADY  out  1  bus ready to master and to all slaves' HREADY inputs.
- HRESP  out  1  response to master.
- err_multi_o  out  1  sticky multi-select flag (see Configuration); cleared only by reset.

## Operation
- Address-phase capture: at a rising HCLK edge with HREADY=1, sel_q is loaded from HSEL_i/HTRANS. With HREADY=0, sel_q holds.
- sel_q encoding: one-hot over NUM_SLV+1 entries. Entry NUM_SLV is the default slave.
- HSEL_i all-zero selects the default slave. A default-slave ERROR sequence starts only if HTRANS is NONSEQ or SEQ.
- Data phase: with slave k selected, HRDATA=HRDATA_s[k], HREADY=HREADYOUT_s[k], HRESP=HRESP_s[k]. All three are purely combinational from sel_q and the slave inputs.
- Default slave FSM:
  - States DS_IDLE, DS_ERR1, DS_ERR2.
  - DS_IDLE: HREADY=1, HRESP=0, HRDATA=0.
  - DS_IDLE -> DS_ERR1 on a captured unmapped NONSEQ/SEQ.
  - DS_ERR1: HREADY=0, HRESP=1; always -> DS_ERR2.
  - DS_ERR2: HREADY=1, HRESP=1. Goes to DS_ERR1 if another unmapped NONSEQ/SEQ is captured this edge, otherwise to DS_IDLE.
- Unmapped IDLE/BUSY: default slave, DS_IDLE, zero-wait OKAY.
- Mapped IDLE/BUSY: routed to the slave normally. The slave itself must give zero-wait OKAY.
- HRDATA reads 0 whenever the default slave is selected.

## Timing
- Reset state: sel_q = default slave, FSM = DS_IDLE, HREADY=1, HRESP=0, HRDATA=0, err_multi_o=0.
- Reset asserted mid-transfer (including during DS_ERR1) forces the reset state immediately, without waiting for a clock edge.
- Zero added latency: the data phase follows the address phase by exactly one HCLK, as the protocol requires.
- Wait states: a slave holding HREADYOUT_s=0 stalls HREADY. sel_q and the pending address phase are held until it rises.
- Back-to-back transfers to different slaves switch the mux on the edge where HREADY=1. There are no bubble cycles.
- An ERROR from a real slave is passed through unmodified, whatever its HREADYOUT sequence.
- A new address phase presented during DS_ERR1 is not captured. The master may change it to IDLE per AHB-Lite.

## Configuration
- AHBLITE_RESP_MUX_ONEHOT_CHK_EN defined:
  - At capture, if HSEL_i has more than one bit set, the transfer is routed to the default slave.
  - It receives the ERROR sequence if NONSEQ/SEQ.
  - err_multi_o is set and stays set.
- Macro undefined:
  - A multi-hot HSEL_i selects the lowest set index.
  - err_multi_o is tied to 0.

## Test plan
- Reset, idle bus -> HREADY=1, HRESP=0, HRDATA=0x00000000, err_multi_o=0.
- NONSEQ read with HSEL_i=0010, slave 1 HRDATA_s=0xA5A5_0001, HREADYOUT_s[1] low for 2 cycles -> HREADY low for 2 cycles, then HRDATA=0xA5A5_0001 with HREADY=1, HRESP=0.
- NONSEQ with HSEL_i=0000:
  - Next cycle: HREADY=0, HRESP=1.
  - Following cycle: HREADY=1, HRESP=1.
  - Then OKAY.
- Back-to-back NONSEQ to slave 0 (0x11111111) then slave 3 (0x33333333), all zero-wait -> HRDATA 0x11111111 then 0x33333333 on consecutive cycles.
- Two consecutive unmapped SEQ transfers -> HRESP=1 over four cycles, with HREADY sequence 0,1,0,1.
- HSEL_i=0110 with NONSEQ:
  - Macro on: ERROR sequence, err_multi_o=1 until reset.
  - Macro off: slave 1 data returned, err_multi_o=0.
- HRESETn pulsed low during DS_ERR1 -> outputs return to reset values without waiting for a clock edge.
